mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the CPU's single unified memory port. It shares one combinational word RAM between the instruction-fetch path and the load/store path. It grants one request at a time using round-robin, holds the memory strobes for a configurable number of wait cycles, and returns registered read data with a one-cycle acknowledge. Misaligned word accesses are rejected with an error instead of reaching memory.

## Interface
Parameters:
- WAIT_CYCLES, default 1: cycles the memory strobe is held per access. Legal range is 1..15.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_req  in  1  fetch request; held with instr_addr stable until instr_ack.
- instr_addr  in  32  fetch byte address.
- instr_ack  out  1  one-cycle completion pulse for fetch.
- instr_err  out  1  valid with instr_ack; 1 means a misaligned address.
- instr_rdata  out  32  fetched word; valid with instr_ack, held afterwards.
- data_req  in  1  load/store request; held with data_we, data_addr and data_wdata stable until data_ack.
- data_we  in  1  1 means store, 0 means load.
- data_addr  in  32  load/store byte address.
- data_wdata  in  32  store data.
- data_ack  out  1  one-cycle completion pulse for load/store.
- data_err  out  1  valid with data_ack; 1 means a misaligned address.
- data_rdata  out  32  loaded word; valid with data_ack on loads, held afterwards.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE: if any request is high, grant one request.
  - Latch the granted request's address, write data and write flag into mem_addr, mem_wdata and an internal we flag.
  - Record the granted port in grant_port and last_grant.
  - If the latched addr[1:0] is 0, go to ACCESS and load wait_cnt with WAIT_CYCLES-1.
  - If addr[1:0] is not 0, set err_q, skip ACCESS and go to RESP.
- Arbitration:
  - If only one port is requesting, it wins.
  - If both are requesting, the port not equal to last_grant wins.
  - last_grant resets to DATA, so fetch wins the first tie.
- ACCESS:
  - mem_read = !we and mem_write = we; these strobes are never both high.
  - wait_cnt decrements each cycle.
  - When wait_cnt is 0: on a read, capture mem_rdata into the granted port's rdata register; then go to RESP.
- RESP:
  - Pulse the granted port's ack, with err = err_q.
  - Clear err_q and go to IDLE.
  - The other port's ack and err stay 0.
- A fetch is always a read; instr_req never writes.
- Misaligned accesses: no memory strobe is asserted. The port's rdata register is unchanged, and err = 1 with the ack.
- Stores leave data_rdata unchanged.
- mem_addr and mem_wdata hold their last latched values outside ACCESS. Strobes are 0 in IDLE and RESP.
- A request dropped before it is granted has no effect. Once granted, a transaction always completes and acks even if the request is withdrawn.
- Reset:
  - At reset, state = IDLE, last_grant = DATA, and wait_cnt, err_q and every output are 0.
  - The rdata registers and mem_addr/mem_wdata also reset to 0.
  - Reset asserted mid-transaction aborts it: strobes are 0 and there is no ack from the next edge on. Requesters must re-issue.

## Timing
- A request is granted in IDLE cycle k.
  - ACCESS covers cycles k+1 .. k+WAIT_CYCLES.
  - The ack is high in cycle k+WAIT_CYCLES+1.
  - IDLE follows in cycle k+WAIT_CYCLES+2.
- Aligned latency from request to ack is WAIT_CYCLES+1 cycles. Throughput is one access per WAIT_CYCLES+2 cycles.
- A misaligned access has latency 1 (ack in k+1) and occupies 2 cycles.
- A request held high through its ack cycle is re-arbitrated in the following IDLE cycle as a new transaction.
  - Requesters deassert in the cycle after the ack unless they intend back-to-back accesses.
- rdata changes only on the clock edge that enters RESP, and is stable while ack is high.

## Test plan
- Fetch alone, WAIT_CYCLES=1, instr_addr=0x100, memory word 0xDEADBEEF:
  - mem_read is high in cycle k+1 only.
  - instr_ack is high in k+2 with instr_rdata=0xDEADBEEF and instr_err=0.
- Store then load, WAIT_CYCLES=3:
  - Store data_addr=0x40, data_wdata=0x12345678: mem_write is high for exactly 3 cycles and data_ack fires 4 cycles after the grant.
  - Load from 0x40 returns 0x12345678.
- Both requesting continuously from reset:
  - Grants alternate instr, data, instr, data.
  - Each ack is spaced WAIT_CYCLES+2 cycles apart, and no port acks twice in a row.
- Misaligned data_addr=0x102:
  - data_ack and data_err are high 1 cycle after the grant.
  - mem_read and mem_write are never asserted, and data_rdata is unchanged.
- Reset asserted in the second ACCESS cycle with WAIT_CYCLES=3:
  - From the next edge, strobes are 0, no ack ever fires, all outputs are 0 and the FSM is in IDLE.
  - A re-issued request then completes normally.
- Request withdrawn the cycle after grant: the transaction still completes with a single ack pulse, and no further ack follows.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter and wait-state sequencer for a unified word RAM
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic DATA = 1'b1;
  state_t state, state_n;
  logic last_grant, grant_port, we, err_q, pick, any_req;
  logic [3:0] wait_cnt;
  logic [31:0] req_addr;
  // Round-robin pick and next-state: misaligned grants bypass ACCESS and answer with an error
  always_comb begin
    any_req = instr_req || data_req;
    pick = (instr_req && data_req) ? ~last_grant : data_req;
    req_addr = pick ? data_addr : instr_addr;
    state_n = state == IDLE ? (any_req ? (req_addr[1:0] == 2'b00 ? ACCESS : RESP) : IDLE)
            : state == ACCESS ? (wait_cnt == 4'd0 ? RESP : ACCESS)
            : IDLE;
  end
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Grant latching, wait counting and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= DATA;
      grant_port <= 1'b0;
      we <= 1'b0;
      err_q <= 1'b0;
      wait_cnt <= 4'd0;
      mem_addr <= '0;
      mem_wdata <= '0;
      instr_rdata <= '0;
      data_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        mem_addr <= req_addr;
        mem_wdata <= pick ? data_wdata : mem_wdata;
        we <= pick && data_we;
        grant_port <= pick;
        last_grant <= pick;
        err_q <= req_addr[1:0] != 2'b00;
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      end
      if (state == ACCESS) begin
        wait_cnt <= wait_cnt - 4'd1;
        if (wait_cnt == 4'd0 && !we && !grant_port) instr_rdata <= mem_rdata;
        if (wait_cnt == 4'd0 && !we && grant_port) data_rdata <= mem_rdata;
      end
      if (state == RESP) err_q <= 1'b0;
    end
  end
  assign mem_read = state == ACCESS && !we;
  assign mem_write = state == ACCESS && we;
  assign instr_ack = state == RESP && !grant_port;
  assign data_ack = state == RESP && grant_port;
  assign instr_err = instr_ack && err_q;
  assign data_err = data_ack && err_q;
endmodule
